// File: rtl/wrap_mem_pkg.sv
// Shared constants and size-code decoding for the wrap_mem byte-addressed data memory.
package wrap_mem_pkg;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic       legal;
    logic [2:0] n;      // access width in bytes: 1, 2 or 4
  } access_size_t;

  function automatic access_size_t decode_size(input logic [3:0] byte_en);
    access_size_t s;
    s = '{legal: 1'b0, n: 3'd0};
    case (byte_en)
      BE_BYTE: s = '{legal: 1'b1, n: 3'd1};
      BE_HALF: s = '{legal: 1'b1, n: 3'd2};
      BE_WORD: s = '{legal: 1'b1, n: 3'd4};
      default: s = '{legal: 1'b0, n: 3'd0};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/wrap_mem_align.sv
// Byte-lane mapping: splits an access of N bytes at a byte address into a
// current/next word pair, with per-word lane masks and shifted store/load data.
module wrap_mem_align
  import wrap_mem_pkg::*;
#(
  parameter int MEM_SIZE_WORDS = 16,
  localparam int ADDR_BITS = $clog2(4 * MEM_SIZE_WORDS),
  localparam int IDX_W     = $clog2(MEM_SIZE_WORDS)
) (
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [2:0]           n,
  input  logic [31:0]          wr_data,
  input  logic [31:0]          word_lo,
  input  logic [31:0]          word_hi,
  output logic [IDX_W-1:0]     idx_lo,
  output logic [IDX_W-1:0]     idx_hi,
  output logic [3:0]           mask_lo,
  output logic [3:0]           mask_hi,
  output logic [31:0]          st_lo,
  output logic [31:0]          st_hi,
  output logic [31:0]          ld_raw
);

  logic [1:0] lane;
  logic [4:0] shamt;
  logic [7:0] mask_pair;

  function automatic logic [3:0] width_mask(input logic [2:0] nb);
    case (nb)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Store data shifted left into a two-word window; upper half spills into the next word.
  function automatic logic [63:0] store_shift(input logic [31:0] d, input logic [4:0] sh);
    return {32'b0, d} << sh;
  endfunction

  // Two adjacent words viewed as one 64-bit window, shifted down to the access lane.
  function automatic logic [31:0] load_merge(input logic [31:0] lo, input logic [31:0] hi,
                                             input logic [4:0] sh);
    logic [63:0] w;
    w = {hi, lo} >> sh;
    return w[31:0];
  endfunction

  assign lane   = addr[1:0];
  assign shamt  = {lane, 3'b000};
  assign idx_lo = addr[ADDR_BITS-1:2];
  // Power-of-two word count makes the increment wrap from the last word to word 0.
  assign idx_hi = idx_lo + 1'b1;

  assign mask_pair        = {4'b0000, width_mask(n)} << lane;
  assign mask_lo          = mask_pair[3:0];
  assign mask_hi          = mask_pair[7:4];
  assign {st_hi, st_lo}   = store_shift(wr_data, shamt);
  assign ld_raw           = load_merge(word_lo, word_hi, shamt);

endmodule

// File: rtl/wrap_mem.sv
// Byte-addressed data memory with misaligned, word-crossing and wrapping
// byte/halfword/word accesses; combinational loads, single-cycle stores.
module wrap_mem
  import wrap_mem_pkg::*;
#(
  parameter int MEM_SIZE_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  input  logic [3:0]  byte_en,
  input  logic        is_signed,
  output logic [31:0] rd_data
);

  localparam int ADDR_BITS = $clog2(4 * MEM_SIZE_WORDS);
  localparam int IDX_W     = $clog2(MEM_SIZE_WORDS);

  logic [31:0] mem [MEM_SIZE_WORDS];

  access_size_t acc;
  logic [IDX_W-1:0] idx_lo, idx_hi;
  logic [3:0]       mask_lo, mask_hi;
  logic [31:0]      st_lo, st_hi, ld_raw;
  logic             unused_addr_bits;

  assign acc              = decode_size(byte_en);
  assign unused_addr_bits = ^addr[31:ADDR_BITS];

  wrap_mem_align #(.MEM_SIZE_WORDS(MEM_SIZE_WORDS)) u_align (
    .addr    (addr[ADDR_BITS-1:0]),
    .n       (acc.n),
    .wr_data (wr_data),
    .word_lo (mem[idx_lo]),
    .word_hi (mem[idx_hi]),
    .idx_lo  (idx_lo),
    .idx_hi  (idx_hi),
    .mask_lo (mask_lo),
    .mask_hi (mask_hi),
    .st_lo   (st_lo),
    .st_hi   (st_hi),
    .ld_raw  (ld_raw)
  );

  // NOTE: the array is cleared on reset because loads after reset must read 0;
  // that forces flops rather than a RAM macro, acceptable at this small size.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_SIZE_WORDS; i++) mem[i] <= '0;
    end else if (wr_en && acc.legal) begin
      // NOTE: non-blocking updates so every lane write sees pre-edge state.
      for (int b = 0; b < 4; b++) begin
        if (mask_lo[b]) mem[idx_lo][8*b +: 8] <= st_lo[8*b +: 8];
        if (mask_hi[b]) mem[idx_hi][8*b +: 8] <= st_hi[8*b +: 8];
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    if (acc.legal) begin
      case (acc.n)
        3'd1:    rd_data = {{24{is_signed & ld_raw[7]}},  ld_raw[7:0]};
        3'd2:    rd_data = {{16{is_signed & ld_raw[15]}}, ld_raw[15:0]};
        default: rd_data = ld_raw;
      endcase
    end
  end

endmodule

// File: tb/tb_wrap_mem.sv
// Directed self-checking bench for wrap_mem (16 words, 64 bytes).
module tb_wrap_mem;
  import wrap_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [3:0]  byte_en;
  logic        is_signed;
  logic [31:0] rd_data;

  int errors = 0;
  int checks = 0;

  wrap_mem #(.MEM_SIZE_WORDS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .byte_en   (byte_en),
    .is_signed (is_signed),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr = a; wr_data = d; byte_en = be; is_signed = 1'b0; wr_en = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic apply_load(input logic [31:0] a, input logic [3:0] be, input logic sgn);
    addr = a; byte_en = be; is_signed = sgn; wr_en = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; addr = '0; wr_data = '0; byte_en = BE_WORD; is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int w = 0; w < 16; w++) begin
      apply_load(32'(w * 4), BE_WORD, 1'b0);
      checks++;
      if (rd_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_word%0d: got %h expected %h", w, rd_data, 32'h0);
      end
    end
  endtask

  task automatic test_word_half();
    logic [31:0] a_t [4] = '{32'd0, 32'd1, 32'd0, 32'd2};
    logic [3:0]  b_t [4] = '{BE_WORD, BE_HALF, BE_WORD, BE_HALF};
    logic        s_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] e_t [4] = '{32'hF0F0F0F0, 32'h0000AAAA, 32'hF0AAAAF0, 32'hFFFFF0F0};
    store(32'd0, 32'hF0F0F0F0, BE_WORD);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) store(32'd1, 32'h0000AAAA, BE_HALF);
      apply_load(a_t[i], b_t[i], s_t[i]);
      checks++;
      if (rd_data !== e_t[i]) begin
        errors++;
        $display("FAIL word_half_%0d: got %h expected %h", i, rd_data, e_t[i]);
      end
    end
    store(32'd2, 32'h0000F0F0, BE_HALF);
    apply_load(a_t[3], b_t[3], s_t[3]);
    checks++;
    if (rd_data !== e_t[3]) begin
      errors++;
      $display("FAIL half_signed_2: got %h expected %h", rd_data, e_t[3]);
    end
    apply_load(32'd0, BE_WORD, 1'b0);
    checks++;
    if (rd_data !== 32'hF0F0AAF0) begin
      errors++;
      $display("FAIL word0_after_half: got %h expected %h", rd_data, 32'hF0F0AAF0);
    end
  endtask

  task automatic test_byte_ext();
    store(32'd5, 32'h000000CC, BE_BYTE);
    apply_load(32'd5, BE_BYTE, 1'b0);
    checks++;
    if (rd_data !== 32'h000000CC) begin
      errors++; $display("FAIL byte_unsigned: got %h expected %h", rd_data, 32'h000000CC);
    end
    apply_load(32'd5, BE_BYTE, 1'b1);
    checks++;
    if (rd_data !== 32'hFFFFFFCC) begin
      errors++; $display("FAIL byte_signed: got %h expected %h", rd_data, 32'hFFFFFFCC);
    end
    store(32'd6, 32'h0000FF00, BE_HALF);
    apply_load(32'd6, BE_HALF, 1'b0);
    checks++;
    if (rd_data !== 32'h0000FF00) begin
      errors++; $display("FAIL half_unsigned_6: got %h expected %h", rd_data, 32'h0000FF00);
    end
    apply_load(32'd6, BE_HALF, 1'b1);
    checks++;
    if (rd_data !== 32'hFFFFFF00) begin
      errors++; $display("FAIL half_signed_6: got %h expected %h", rd_data, 32'hFFFFFF00);
    end
    apply_load(32'd4, BE_WORD, 1'b1);
    checks++;
    if (rd_data !== 32'hFF00CC00) begin
      errors++; $display("FAIL word4: got %h expected %h", rd_data, 32'hFF00CC00);
    end
  endtask

  task automatic test_byte_in_word();
    store(32'd8, 32'hAAAAAAAA, BE_WORD);
    store(32'd11, 32'h00000033, BE_BYTE);
    apply_load(32'd11, BE_BYTE, 1'b0);
    checks++;
    if (rd_data !== 32'h00000033) begin
      errors++; $display("FAIL byte11: got %h expected %h", rd_data, 32'h00000033);
    end
    apply_load(32'd8, BE_WORD, 1'b0);
    checks++;
    if (rd_data !== 32'h33AAAAAA) begin
      errors++; $display("FAIL word8: got %h expected %h", rd_data, 32'h33AAAAAA);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a_t [6] = '{32'd60, 32'd0, 32'd62, 32'd64, 32'h0000_013E, 32'd63};
    logic [3:0]  b_t [6] = '{BE_WORD, BE_WORD, BE_WORD, BE_WORD, BE_WORD, BE_HALF};
    logic [31:0] e_t [6] = '{32'h33440000, 32'hF0F01122, 32'h11223344,
                             32'hF0F01122, 32'h11223344, 32'h00002233};
    store(32'd62, 32'h11223344, BE_WORD);
    for (int i = 0; i < 6; i++) begin
      apply_load(a_t[i], b_t[i], 1'b0);
      checks++;
      if (rd_data !== e_t[i]) begin
        errors++;
        $display("FAIL wrap_%0d addr %h: got %h expected %h", i, a_t[i], rd_data, e_t[i]);
      end
    end
  endtask

  task automatic test_store_timing();
    @(negedge clk);
    addr = 32'd21; wr_data = 32'h12345678; byte_en = BE_WORD; is_signed = 1'b0; wr_en = 1'b1;
    #1;
    checks++;
    if (rd_data !== 32'h00000000) begin
      errors++; $display("FAIL pre_edge: got %h expected %h", rd_data, 32'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rd_data !== 32'h12345678) begin
      errors++; $display("FAIL post_edge: got %h expected %h", rd_data, 32'h12345678);
    end
    wr_en = 1'b0;
    apply_load(32'd20, BE_WORD, 1'b0);
    checks++;
    if (rd_data !== 32'h34567800) begin
      errors++; $display("FAIL cross_word20: got %h expected %h", rd_data, 32'h34567800);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    addr = 32'd0; wr_data = 32'hFFFFFFFF; byte_en = 4'b0101; is_signed = 1'b1; wr_en = 1'b1;
    #1;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++; $display("FAIL illegal_rd: got %h expected %h", rd_data, 32'h0);
    end
    @(posedge clk);
    #1 wr_en = 1'b0;
    apply_load(32'd0, BE_WORD, 1'b0);
    checks++;
    if (rd_data !== 32'hF0F01122) begin
      errors++; $display("FAIL illegal_nowrite: got %h expected %h", rd_data, 32'hF0F01122);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst = 1'b1; addr = 32'd4; wr_data = 32'hDEADBEEF; byte_en = BE_WORD; wr_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; wr_en = 1'b0;
    for (int w = 0; w < 16; w++) begin
      apply_load(32'(w * 4 + 1), BE_WORD, 1'b1);
      checks++;
      if (rd_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_prio_word%0d: got %h expected %h", w, rd_data, 32'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_half();
    test_byte_ext();
    test_byte_in_word();
    test_wrap();
    test_store_timing();
    test_illegal();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wrap_mem.md
# wrap_mem

Byte-addressed data memory for the core's load/store path. It stores `MEM_SIZE_WORDS` 32-bit words. It accepts byte, halfword and word accesses at any byte address, including misaligned and word-crossing ones. Addresses wrap modulo the memory size. Loads return zero- or sign-extended data.

## Interface
- `MEM_SIZE_WORDS`, default 16: number of 32-bit words; power of two, ≥2. Byte capacity is `4*MEM_SIZE_WORDS`.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `addr` input 32: byte address; only the low `log2(4*MEM_SIZE_WORDS)` bits are used.
- `wr_data` input 32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `wr_en` input 1: store strobe, sampled on rising `clk`.
- `byte_en` input 4: access size. 0001 = byte, 0011 = halfword, 1111 = word. All other codes are illegal.
- `is_signed` input 1: sign-extend narrow loads when 1, zero-extend when 0.
- `rd_data` output 32: load data, right-aligned and extended.

## Operation
- Storage is an array of `MEM_SIZE_WORDS` × 32-bit words, little-endian. Byte address A maps to word `(A>>2) mod MEM_SIZE_WORDS`, lane `A[1:0]`.
- Access width N is 1, 2 or 4 bytes. The access covers bytes A, A+1, …, A+N-1, each taken modulo the byte capacity.
- Misaligned accesses are legal, including ones that span two words. The upper byte(s) go to the next word index. From the last word this wraps to word 0.
- Store with `wr_en`=1 and a legal `byte_en`:
  - Byte k of `wr_data` (k < N) is written to byte address A+k.
  - All other bytes are unchanged.
- Load is always active and combinational from `addr`, `byte_en` and `is_signed`:
  - Byte k of the result is the byte at A+k, for k < N.
  - Upper bits are filled with the MSB of the loaded data when `is_signed`=1, else with zero.
  - `is_signed` has no effect for word loads.
- Illegal `byte_en`: the store is suppressed and `rd_data` = 0.
- Reset: while `rst`=1 at a rising edge, every word is cleared to 0.
  - Reset has priority over a simultaneous store.
  - After reset every load returns 0.

## Timing
- Store latency is 1 cycle. Bytes update at the rising edge where `wr_en`=1, and are visible on `rd_data` immediately after that edge.
- Load latency is 0 cycles (combinational).
  - In a store cycle, `rd_data` shows the pre-edge contents until the edge, then the new contents.
- There is no handshake or stall; every cycle can carry an access.
- `rd_data` reset value: 0, valid from the first cycle after the reset edge.

## Structure
- Package `wrap_mem_pkg` holds:
  - size-code constants `BE_BYTE`=4'b0001, `BE_HALF`=4'b0011, `BE_WORD`=4'b1111;
  - a function converting a size code to N, flagging illegal codes.
- Sub-module `wrap_mem_align` handles byte-lane mapping:
  - From address and N, it produces the two word indices (current and next, wrapped) and per-word byte masks.
  - It also provides rotate/shift functions for store data and the load merge.
- Top level holds the array, the write logic, reset clearing and the load extension.

## Test plan
- Word store F0F0F0F0 at addr 0, then word load at 0 → F0F0F0F0. Then halfword store AAAA at addr 1 → halfword load at 1 (unsigned) returns 0000AAAA, and word load at 0 returns F0AAAAF0.
- Byte store CC at addr 5 → unsigned byte load at 5 = 000000CC; signed = FFFFFFCC. Halfword store FF00 at addr 6 → unsigned halfword load at 6 = 0000FF00.
- Word store AAAAAAAA at addr 8, then byte store 33 at addr 11 → byte load at 11 = 00000033; word load at 8 = 33AAAAAA.
- With memory in the state left by the first scenario, halfword store F0F0 at addr 2, then signed halfword load at 2 → FFFFF0F0; word load at 0 → F0F0AAF0.
- Wrap-around with 16 words: word store 11223344 at addr 62.
  - Word 15 [31:16] = 3344 and word 0 [15:0] = 1122; other bytes are unchanged.
  - Word load at 62 → 11223344.
  - Word load at addr 64 reads word 0.
- Reset and illegal codes:
  - Assert `rst` for one cycle together with `wr_en` → all loads return 0 and the store is dropped.
  - A store with `byte_en`=0101 changes nothing, and `rd_data` = 0 while that code is applied.
